game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Upstream controller for board_updater; owns the authoritative game state: current board, ko board, side to move, pass count and move count.
- Accepts move requests over a valid/ready handshake and pre-rejects occupied or out-of-range points.
- Forwards legal candidates to board_updater and waits for its one-cycle valid/invalid pulse.
- On a valid result, commits board_updater's next_board, rotates the ko board and flips the turn.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles in WAIT_UPD before the move is abandoned.
- CNT_W, 8: width of move_count_out.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- new_game_in  input  1  synchronous clear to the empty board; honoured in any state.
- move_valid_in  input  1  move request valid.
- move_in  input  8  [7:4] row, [3:0] col; 8'hFF means pass.
- move_ready_out  output  1  high only in IDLE.
- upd_start_out  output  1  one-cycle start pulse to board_updater.
- upd_move_out  output  8  latched move.
- upd_turn_out  output  1  latched side to move; 1 = White.
- cur_board_out  output  2x9x9  committed board; feeds board_updater board_bus.
- ko_board_out  output  2x9x9  board before the last committed move; feeds ko_board.
- upd_board_in  input  2x9x9  board_updater next_board.
- upd_valid_in  input  1  board_updater board_valid pulse.
- upd_invalid_in  input  1  board_updater board_invalid pulse.
- turn_out  output  1  side to move.
- accepted_out  output  1  one-cycle pulse when a move or pass commits.
- rejected_out  output  1  one-cycle pulse when a move is refused.
- timeout_err_out  output  1  sticky; cleared by reset or new_game_in.
- game_over_out  output  1  high after two consecutive passes.
- move_count_out  output  CNT_W  committed moves and passes; saturates at all-ones.

Behaviour:
- Reset (rst_in low, async): all outputs zero except move_ready_out; state IDLE; boards all EMPTY; turn 0 (Black); pass count 0.
- move_ready_out = (state==IDLE), so it reads 1 once reset releases.
- Stone encoding: EMPTY 2'b00, BLACK 2'b01, WHITE 2'b10. A stone placed by side t is {t,~t}.
- IDLE: when move_valid_in && move_ready_out, latch move_in into upd_move_out and turn_out into upd_turn_out; go to CHECK.
- CHECK (one cycle):
  - Pass -> COMMIT_PASS.
  - Row > 8, col > 8, or cur_board_out[row][col] != EMPTY -> REJECT.
  - Otherwise -> ISSUE.
- ISSUE: upd_start_out = 1 for exactly one cycle -> WAIT_UPD. The cycle counter is cleared here.
- WAIT_UPD:
  - upd_invalid_in -> REJECT. This takes priority if upd_valid_in is asserted in the same cycle.
  - Else upd_valid_in -> COMMIT.
  - Else if the counter reaches TIMEOUT_CYCLES-1 -> set timeout_err_out, go to REJECT.
  - Inputs cur_board_out, ko_board_out and upd_turn_out stay frozen for the whole wait.
- COMMIT:
  - ko <= cur, cur <= upd_board_in, turn flips, pass count <= 0, move_count increments (saturating), accepted_out pulses.
  - -> IDLE.
- COMMIT_PASS:
  - ko <= cur (board unchanged), turn flips, move_count increments, accepted_out pulses.
  - Pass count increments; if it reaches 2 -> GAME_OVER, else -> IDLE.
- REJECT: rejected_out pulses; board, turn and pass count unchanged -> IDLE.
- GAME_OVER: game_over_out = 1, move_ready_out = 0; exits only on reset or new_game_in.
- new_game_in: synchronous; same effect as reset except timing. Takes precedence over every transition, including a valid pulse arriving in the same cycle.
- Request-to-response latency:
  - Pre-reject: accepted at cycle T, rejected_out at T+2, ready again at T+3.
  - Pass: accepted_out at T+2.
  - Normal move: start at T+2; commit is 1 cycle after upd_valid_in.
- upd_valid_in or upd_invalid_in arriving outside WAIT_UPD: ignored.

Decomposition:
- go_pkg holds:
  - stone_t enum (EMPTY, BLACK, WHITE).
  - BOARD_DIM = 9.
  - board_t as a 2-bit [8:0][8:0] array.
  - PASS_MOVE = 8'hFF.
  - EMPTY_BOARD constant.
- One natural sub-module: move_precheck. It is combinational and takes board, move and turn. It returns is_pass, out_of_range and occupied.
- The FSM, registers and counters stay in game_sequencer.

Test Plan:
- Reset, then move 8'h44 from Black; model returns valid with [4][4]=01 -> cur[4][4]=01, ko all EMPTY, turn_out=1, move_count=1, accepted_out pulse.
- After the above, White plays 8'h44 -> rejected_out at T+2, no upd_start_out pulse, board and turn unchanged.
- Move 8'h49 (col 9) -> pre-rejected. Separately, a move with upd_valid_in and upd_invalid_in asserted together -> treated as invalid, rejected_out, no commit.
- Pass, pass -> accepted_out twice, game_over_out=1, move_ready_out=0, move_count=2. new_game_in -> empty board, turn 0, game_over_out=0.
- Pass, move 8'h00 (valid), pass -> pass count resets, no game over. ko_board_out equals cur_board_out from before the last commit.
- Legal move with the model silent -> upd_start_out once; after 1024 cycles rejected_out and timeout_err_out=1. Repeat with rst_in asserted mid-WAIT_UPD -> immediate return to the reset state.

Source files
------------

// File: rtl/go_pkg.sv
// Shared types and constants for the Go game controller: stone encoding,
// board layout, the pass sentinel and the sequencer state encoding.
package go_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10
  } stone_t;

  localparam int BOARD_DIM = 9;

  // Indexed as board[row][col]; each point holds a 2-bit stone code.
  typedef logic [BOARD_DIM-1:0][BOARD_DIM-1:0][1:0] board_t;

  localparam logic [7:0] PASS_MOVE   = 8'hFF;
  localparam board_t     EMPTY_BOARD = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT_UPD,
    S_COMMIT,
    S_COMMIT_PASS,
    S_REJECT,
    S_GAME_OVER
  } seq_state_t;

  // Stone code for a stone placed by side t (0 = Black, 1 = White).
  function automatic logic [1:0] stone_of(input logic t);
    return {t, ~t};
  endfunction

endpackage

// File: rtl/move_precheck.sv
// Combinational screening of a move request against the committed board:
// classifies it as a pass, an off-board point, or an already occupied point.
module move_precheck
  import go_pkg::*;
(
  input  board_t     board,
  input  logic [7:0] move,
  output logic       is_pass,
  output logic       out_of_range,
  output logic       occupied
);

  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] row_i;
  logic [3:0] col_i;

  assign row = move[7:4];
  assign col = move[3:0];

  assign is_pass      = (move == PASS_MOVE);
  assign out_of_range = !is_pass && ((row > 4'd8) || (col > 4'd8));

  // Clamp the lookup so an off-board request never indexes past the array.
  assign row_i = out_of_range ? 4'd0 : row;
  assign col_i = out_of_range ? 4'd0 : col;

  assign occupied = !is_pass && !out_of_range &&
                    (stone_t'(board[row_i][col_i]) != EMPTY);

endmodule

// File: rtl/game_sequencer.sv
// Authoritative game-state owner: screens move requests, hands legal ones to
// board_updater, and commits its result along with ko board, turn and counts.
module game_sequencer
  import go_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             new_game_in,
  input  logic             move_valid_in,
  input  logic [7:0]       move_in,
  output logic             move_ready_out,
  output logic             upd_start_out,
  output logic [7:0]       upd_move_out,
  output logic             upd_turn_out,
  output board_t           cur_board_out,
  output board_t           ko_board_out,
  input  board_t           upd_board_in,
  input  logic             upd_valid_in,
  input  logic             upd_invalid_in,
  output logic             turn_out,
  output logic             accepted_out,
  output logic             rejected_out,
  output logic             timeout_err_out,
  output logic             game_over_out,
  output logic [CNT_W-1:0] move_count_out
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  seq_state_t       state;
  logic [TMR_W-1:0] tmr;
  logic [1:0]       pass_cnt;

  logic is_pass;
  logic out_of_range;
  logic occupied;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  move_precheck u_precheck (
    .board        (cur_board_out),
    .move         (upd_move_out),
    .is_pass      (is_pass),
    .out_of_range (out_of_range),
    .occupied     (occupied)
  );

  assign move_ready_out = (state == S_IDLE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= S_IDLE;
      tmr             <= '0;
      pass_cnt        <= '0;
      upd_start_out   <= 1'b0;
      upd_move_out    <= '0;
      upd_turn_out    <= 1'b0;
      cur_board_out   <= EMPTY_BOARD;
      ko_board_out    <= EMPTY_BOARD;
      turn_out        <= 1'b0;
      accepted_out    <= 1'b0;
      rejected_out    <= 1'b0;
      timeout_err_out <= 1'b0;
      game_over_out   <= 1'b0;
      move_count_out  <= '0;
    end else if (new_game_in) begin
      state           <= S_IDLE;
      tmr             <= '0;
      pass_cnt        <= '0;
      upd_start_out   <= 1'b0;
      upd_move_out    <= '0;
      upd_turn_out    <= 1'b0;
      cur_board_out   <= EMPTY_BOARD;
      ko_board_out    <= EMPTY_BOARD;
      turn_out        <= 1'b0;
      accepted_out    <= 1'b0;
      rejected_out    <= 1'b0;
      timeout_err_out <= 1'b0;
      game_over_out   <= 1'b0;
      move_count_out  <= '0;
    end else begin
      upd_start_out <= 1'b0;
      accepted_out  <= 1'b0;
      rejected_out  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (move_valid_in) begin
            upd_move_out <= move_in;
            upd_turn_out <= turn_out;
            state        <= S_CHECK;
          end
        end
        // Pass bookkeeping is applied on leaving CHECK so accepted_out lands two cycles after the request.
        S_CHECK: begin
          if (is_pass) begin
            ko_board_out   <= cur_board_out;
            turn_out       <= ~turn_out;
            move_count_out <= sat_inc(move_count_out);
            pass_cnt       <= pass_cnt + 2'd1;
            accepted_out   <= 1'b1;
            state          <= S_COMMIT_PASS;
          end else if (out_of_range || occupied) begin
            rejected_out <= 1'b1;
            state        <= S_REJECT;
          end else begin
            upd_start_out <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmr   <= '0;
          state <= S_WAIT_UPD;
        end
        S_WAIT_UPD: begin
          if (upd_invalid_in) begin
            rejected_out <= 1'b1;
            state        <= S_REJECT;
          end else if (upd_valid_in) begin
            ko_board_out   <= cur_board_out;
            cur_board_out  <= upd_board_in;
            turn_out       <= ~turn_out;
            pass_cnt       <= '0;
            move_count_out <= sat_inc(move_count_out);
            accepted_out   <= 1'b1;
            state          <= S_COMMIT;
          end else if (tmr == TMR_LAST) begin
            timeout_err_out <= 1'b1;
            rejected_out    <= 1'b1;
            state           <= S_REJECT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_COMMIT: state <= S_IDLE;
        S_COMMIT_PASS: begin
          if (pass_cnt == 2'd2) begin
            game_over_out <= 1'b1;
            state         <= S_GAME_OVER;
          end else begin
            state <= S_IDLE;
          end
        end
        S_REJECT:    state <= S_IDLE;
        S_GAME_OVER: state <= S_GAME_OVER;
        default:     state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer; the bench plays the board_updater role by
// hand, supplying next_board and the valid/invalid pulses.
module tb_game_sequencer;
  import go_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       new_game_in = 1'b0;
  logic       move_valid_in = 1'b0;
  logic [7:0] move_in = 8'h00;
  board_t     upd_board_in = EMPTY_BOARD;
  logic       upd_valid_in = 1'b0;
  logic       upd_invalid_in = 1'b0;

  logic       move_ready_out;
  logic       upd_start_out;
  logic [7:0] upd_move_out;
  logic       upd_turn_out;
  board_t     cur_board_out;
  board_t     ko_board_out;
  logic       turn_out;
  logic       accepted_out;
  logic       rejected_out;
  logic       timeout_err_out;
  logic       game_over_out;
  logic [7:0] move_count_out;

  int n_chk = 0;
  int n_pass = 0;
  int start_cnt = 0;

  game_sequencer #(.TIMEOUT_CYCLES(1024), .CNT_W(8)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .new_game_in     (new_game_in),
    .move_valid_in   (move_valid_in),
    .move_in         (move_in),
    .move_ready_out  (move_ready_out),
    .upd_start_out   (upd_start_out),
    .upd_move_out    (upd_move_out),
    .upd_turn_out    (upd_turn_out),
    .cur_board_out   (cur_board_out),
    .ko_board_out    (ko_board_out),
    .upd_board_in    (upd_board_in),
    .upd_valid_in    (upd_valid_in),
    .upd_invalid_in  (upd_invalid_in),
    .turn_out        (turn_out),
    .accepted_out    (accepted_out),
    .rejected_out    (rejected_out),
    .timeout_err_out (timeout_err_out),
    .game_over_out   (game_over_out),
    .move_count_out  (move_count_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (upd_start_out) start_cnt++;

  task automatic chk(input string tag, input logic [161:0] obs, input logic [161:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [7:0] m);
    move_in       = m;
    move_valid_in = 1'b1;
    tick;
    move_valid_in = 1'b0;
  endtask

  function automatic board_t put(input board_t b, input int r, input int c, input logic [1:0] s);
    board_t t;
    t = b;
    t[r][c] = s;
    return t;
  endfunction

  initial begin
    board_t b44;
    board_t b00;
    int     k;
    int     n;

    #2;
    chk("rst_ready", move_ready_out, 1'b1);
    chk("rst_pulses", {upd_start_out, accepted_out, rejected_out, timeout_err_out, game_over_out, turn_out}, 6'd0);
    chk("rst_board", cur_board_out, EMPTY_BOARD);
    chk("rst_count", move_count_out, 8'd0);
    #10 rst_in = 1'b1;
    tick;

    // Black plays 4-4, updater accepts
    b44 = put(EMPTY_BOARD, 4, 4, stone_of(1'b0));
    send(8'h44);
    chk("b44_latch_move", upd_move_out, 8'h44);
    chk("b44_latch_turn", upd_turn_out, 1'b0);
    tick;
    chk("b44_start", upd_start_out, 1'b1);
    tick;
    chk("b44_start_once", upd_start_out, 1'b0);
    upd_board_in = b44;
    upd_valid_in = 1'b1;
    tick;
    upd_valid_in = 1'b0;
    chk("b44_accepted", accepted_out, 1'b1);
    chk("b44_cur", cur_board_out, b44);
    chk("b44_ko", ko_board_out, EMPTY_BOARD);
    chk("b44_turn", turn_out, 1'b1);
    chk("b44_count", move_count_out, 8'd1);
    tick;
    chk("b44_acc_drop", accepted_out, 1'b0);
    chk("b44_ready", move_ready_out, 1'b1);

    // White 4-4 onto an occupied point
    k = start_cnt;
    send(8'h44);
    tick;
    chk("occ_rejected", rejected_out, 1'b1);
    tick;
    chk("occ_ready", move_ready_out, 1'b1);
    chk("occ_no_start", start_cnt, k);
    chk("occ_board", cur_board_out, b44);
    chk("occ_turn", turn_out, 1'b1);

    // Column 9 is off the board
    send(8'h49);
    tick;
    chk("col9_rejected", rejected_out, 1'b1);
    chk("col9_no_start", start_cnt, k);
    tick;

    // Valid and invalid together resolve as invalid
    send(8'h22);
    tick;
    tick;
    upd_board_in   = put(b44, 2, 2, stone_of(1'b1));
    upd_valid_in   = 1'b1;
    upd_invalid_in = 1'b1;
    tick;
    upd_valid_in   = 1'b0;
    upd_invalid_in = 1'b0;
    chk("both_rejected", rejected_out, 1'b1);
    chk("both_no_accept", accepted_out, 1'b0);
    tick;
    chk("both_board", cur_board_out, b44);
    chk("both_count", move_count_out, 8'd1);
    chk("both_turn", turn_out, 1'b1);

    // new_game in the same cycle as a valid pulse wins
    send(8'h33);
    tick;
    tick;
    upd_board_in = put(b44, 3, 3, stone_of(1'b1));
    upd_valid_in = 1'b1;
    new_game_in  = 1'b1;
    tick;
    upd_valid_in = 1'b0;
    new_game_in  = 1'b0;
    chk("ng_no_accept", accepted_out, 1'b0);
    chk("ng_board", cur_board_out, EMPTY_BOARD);
    chk("ng_turn", turn_out, 1'b0);
    chk("ng_count", move_count_out, 8'd0);
    chk("ng_ready", move_ready_out, 1'b1);

    // Two consecutive passes end the game
    send(PASS_MOVE);
    tick;
    chk("pass1_accepted", accepted_out, 1'b1);
    chk("pass1_turn", turn_out, 1'b1);
    tick;
    send(PASS_MOVE);
    tick;
    chk("pass2_accepted", accepted_out, 1'b1);
    tick;
    chk("go_flag", game_over_out, 1'b1);
    chk("go_ready", move_ready_out, 1'b0);
    chk("go_count", move_count_out, 8'd2);
    k = start_cnt;
    move_in       = 8'h55;
    move_valid_in = 1'b1;
    tick;
    tick;
    move_valid_in = 1'b0;
    chk("go_stays", game_over_out, 1'b1);
    chk("go_ignores_move", start_cnt, k);
    new_game_in = 1'b1;
    tick;
    new_game_in = 1'b0;
    chk("go_cleared", game_over_out, 1'b0);
    chk("go_ng_turn", turn_out, 1'b0);
    chk("go_ng_count", move_count_out, 8'd0);
    chk("go_ng_ready", move_ready_out, 1'b1);

    // Pass, White move 0-0, pass: the move breaks the pass streak
    send(PASS_MOVE);
    tick;
    tick;
    b00 = put(EMPTY_BOARD, 0, 0, stone_of(1'b1));
    send(8'h00);
    tick;
    tick;
    upd_board_in = b00;
    upd_valid_in = 1'b1;
    tick;
    upd_valid_in = 1'b0;
    chk("pmp_ko_move", ko_board_out, EMPTY_BOARD);
    chk("pmp_cur_move", cur_board_out, b00);
    tick;
    send(PASS_MOVE);
    tick;
    chk("pmp_accepted", accepted_out, 1'b1);
    chk("pmp_ko_pass", ko_board_out, b00);
    chk("pmp_cur_pass", cur_board_out, b00);
    tick;
    chk("pmp_no_gameover", game_over_out, 1'b0);
    chk("pmp_count", move_count_out, 8'd3);
    chk("pmp_turn", turn_out, 1'b1);
    chk("pmp_ready", move_ready_out, 1'b1);

    // Silent updater: move is abandoned after the timeout
    k = start_cnt;
    send(8'h11);
    tick;
    tick;
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      tick;
      if (rejected_out) begin
        n = i + 1;
        break;
      end
    end
    chk("to_wait_cycles", n, 1024);
    chk("to_err", timeout_err_out, 1'b1);
    chk("to_one_start", start_cnt, k + 1);
    chk("to_board", cur_board_out, b00);
    chk("to_turn", turn_out, 1'b1);
    tick;
    chk("to_ready", move_ready_out, 1'b1);
    chk("to_err_sticky", timeout_err_out, 1'b1);

    // Asynchronous reset in the middle of a wait
    send(8'h12);
    tick;
    tick;
    repeat (10) tick;
    rst_in = 1'b0;
    #1;
    chk("ar_ready", move_ready_out, 1'b1);
    chk("ar_board", cur_board_out, EMPTY_BOARD);
    chk("ar_ko", ko_board_out, EMPTY_BOARD);
    chk("ar_turn", turn_out, 1'b0);
    chk("ar_count", move_count_out, 8'd0);
    chk("ar_err", timeout_err_out, 1'b0);
    chk("ar_move", upd_move_out, 8'h00);
    tick;
    rst_in = 1'b1;
    tick;
    chk("ar_ready_after", move_ready_out, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
